uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO between the CPU-side UART transmit register path and the UART transmitter in the RISC-V multicycle SoC. CPU stores to the TX data register push bytes. A drain state machine pops them one at a time, issues a one-cycle start pulse to the transmitter, and waits for its completion pulse before sending the next byte. Status outputs (full, empty, count, sticky overflow) feed the UART status register decode.

## Interface
- DEPTH, 8, number of byte entries; must be a power of two, ≥ 2
- DATA_WIDTH, 8, entry width in bits
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en_i  in  1  push request, one byte per cycle while high
- wr_data_i  in  DATA_WIDTH  byte to push
- tx_done_i  in  1  one-cycle pulse from transmitter at end of stop bit
- clr_overflow_i  in  1  clears overflow_o
- tx_start_o  out  1  one-cycle start pulse to transmitter
- tx_data_o  out  DATA_WIDTH  byte being transmitted; stable from tx_start_o until tx_done_i
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- count_o  out  $clog2(DEPTH)+1  entries currently stored
- overflow_o  out  1  sticky: a push was dropped while full
- busy_o  out  1  drain FSM not in IDLE

## Operation
- Storage: DEPTH×DATA_WIDTH register array.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count_o is a separate counter.
- Push: on wr_en_i && !full_o, store at wr_ptr, then increment wr_ptr.
  - full_o is evaluated on pre-edge state. A push while full is dropped and sets overflow_o, even if a pop happens on the same edge.
- Overflow: overflow_o clears on clr_overflow_i. If set and clear happen on the same edge, set wins.
- Drain FSM states:
  - IDLE → START when !empty_o. On that edge: tx_data_o ← mem[rd_ptr], rd_ptr increments, count decrements (pop).
  - START → WAIT unconditionally. tx_start_o = 1 only in START (Moore, registered state).
  - WAIT → IDLE on tx_done_i.
- tx_done_i outside WAIT is ignored.
- Count on a simultaneous push and pop: count unchanged, both pointers advance.
- count_o changes by at most 1 per edge. No underflow is possible; the pop is gated by !empty_o.
- Reset, including mid-transmission:
  - State forced to IDLE.
  - Pointers and count go to 0, and array contents are don't-care.
  - Reset values: tx_start_o=0, tx_data_o=0, empty_o=1, full_o=0, count_o=0, overflow_o=0, busy_o=0.
  - Any in-flight byte is abandoned; the transmitter is reset by the same rst.

## Timing
- Write-to-start latency from empty and IDLE:
  - Push sampled at edge N: count_o=1 after N.
  - Edge N+1: pop and enter START; tx_start_o high for cycle N+1..N+2, count_o=0.
  - Edge N+2: enter WAIT.
- Back-to-back bytes: tx_done_i sampled at edge M → IDLE. If non-empty, edge M+1 → START. The inter-byte gap is 2 clk beyond the transmitter's own frame time.
- tx_data_o changes only on the IDLE→START edge.
- All status outputs are registered or decoded from registered state; none depend combinationally on inputs.

## Test plan
- Reset: assert rst=0 mid-WAIT with count_o=3.
  - Required: all outputs take their reset values immediately (asynchronous).
  - Required: after rst=1 with no pushes, no tx_start_o pulse occurs.
- Single byte: push 0xA5 at edge N.
  - Required: tx_start_o high exactly one cycle after edge N+1, tx_data_o=0xA5, busy_o=1.
  - Then pulse tx_done_i 20 cycles later → busy_o=0 next edge, empty_o=1.
- Fill/full: hold transmitter (no tx_done_i) and push 0x01..0x09 on consecutive cycles.
  - Required: 0x01 popped to tx_data_o; count_o reaches 8, full_o=1.
  - Required: 0x0A is not stored; push 0x0A → overflow_o=1.
  - Then pulse clr_overflow_i → overflow_o=0.
- Order and wrap: stream 20 bytes 0x10..0x23, pulsing tx_done_i 5 cycles after each tx_start_o.
  - Required: transmitted sequence exactly 0x10..0x23 across pointer wrap, no duplicates, final empty_o=1.
- Simultaneous push/pop: count_o=3 in IDLE, push 0x55 on the IDLE→START edge.
  - Required: count_o stays 3, and 0x55 is transmitted 4th.
- Stray done and set/clear conflict:
  - tx_done_i in IDLE and START → no state change.
  - overflow set and clr_overflow_i on the same edge → overflow_o=1.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// CPU/transmitter-side bundle for the UART TX byte FIFO.
// The master drives push/done/clear requests; the slave (the FIFO) returns start, data and status.
interface uart_tx_fifo_if #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  tx_done;
   logic                  clr_overflow;
   logic                  tx_start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  full;
   logic                  empty;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  busy;

   modport master (
      output wr_en, wr_data, tx_done, clr_overflow,
      input  tx_start, tx_data, full, empty, count, overflow, busy
   );

   modport slave (
      input  wr_en, wr_data, tx_done, clr_overflow,
      output tx_start, tx_data, full, empty, count, overflow, busy
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: CPU pushes bytes, a drain FSM pops one,
// pulses tx_start and waits for tx_done before releasing the next byte.
module uart_tx_fifo #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   uart_tx_fifo_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [1:0]            state, state_nxt;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count_q, count_nxt;
   logic                  full_q, empty_q, overflow_q, overflow_nxt;
   logic                  tx_start_q, busy_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  push, pop;

   // Next-state, push/pop qualification and status update; full/empty come from pre-edge state.
   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      push         = bus.wr_en && !full_q;
      overflow_nxt = overflow_q;
      count_nxt    = count_q;

      case (state)
         S_IDLE: begin
            if (!empty_q) begin
               state_nxt = S_START;
               pop       = 1'b1;
            end
         end
         S_START: state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus.tx_done) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (push && !pop)      count_nxt = count_q + CNT_W'(1);
      else if (pop && !push) count_nxt = count_q - CNT_W'(1);

      // A dropped push wins over a same-edge clear.
      if (bus.wr_en && full_q)   overflow_nxt = 1'b1;
      else if (bus.clr_overflow) overflow_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state      <= state_nxt;
         count_q    <= count_nxt;
         full_q     <= (count_nxt == CNT_W'(DEPTH));
         empty_q    <= (count_nxt == '0);
         overflow_q <= overflow_nxt;
         tx_start_q <= (state_nxt == S_START);
         busy_q     <= (state_nxt != S_IDLE);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            tx_data_q <= mem[rd_ptr];
         end
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wr_data;
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table plus hand-written
// sequences for reset mid-transmission, pointer wrap, push/pop overlap and stray done.
module tb_uart_tx_fifo;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   uart_tx_fifo_if #(.DEPTH(8), .DATA_WIDTH(8)) bus ();

   uart_tx_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         reps;
      logic       we;
      logic [7:0] wd;
      logic       done;
      logic       clr;
      logic       e_start;
      logic [7:0] e_data;
      logic [3:0] e_count;
      logic       e_full;
      logic       e_empty;
      logic       e_ovf;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en        = 1'b0;
      bus.wr_data      = 8'h00;
      bus.tx_done      = 1'b0;
      bus.clr_overflow = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".tx_start"}, 32'(bus.tx_start), 0);
      check({tag, ".tx_data"},  32'(bus.tx_data),  0);
      check({tag, ".empty"},    32'(bus.empty),    1);
      check({tag, ".full"},     32'(bus.full),     0);
      check({tag, ".count"},    32'(bus.count),    0);
      check({tag, ".overflow"}, 32'(bus.overflow), 0);
      check({tag, ".busy"},     32'(bus.busy),     0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic done_pulse();
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
   endtask

   // Wait (bounded) for the next start pulse, check its byte, then ack after gap cycles.
   task automatic xmit(input logic [7:0] exp, input int gap);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.tx_start) begin
            seen = 1'b1;
            break;
         end
      end
      check($sformatf("xmit_%02h.start_seen", exp), 32'(seen), 1);
      check($sformatf("xmit_%02h.data", exp), 32'(bus.tx_data), 32'(exp));
      repeat (gap - 1) step();
      done_pulse();
   endtask

   initial begin
      logic seen_start;
      int   guard;

      // Table: inputs applied for reps cycles, outputs checked after each edge.
      //            reps we wd     dn clr   st data   cnt full emp ovf busy
      vecs.push_back('{1,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{17, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1,  1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h01, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h01, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h01, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 8'h01, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h01, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 8'h01, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1,  1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h02, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1});

      idle_inputs();
      rst = 1'b1;
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      #3 rst = 1'b1;

      // Reset mid-WAIT with three bytes queued.
      push_byte(8'hC0);
      push_byte(8'hC1);
      push_byte(8'hC2);
      push_byte(8'hC3);
      check("pre_rst.count", 32'(bus.count), 3);
      check("pre_rst.busy",  32'(bus.busy),  1);
      check("pre_rst.data",  32'(bus.tx_data), 32'h C0);
      #2 rst = 1'b0;
      #1 check_reset_vals("async_rst");
      #3 rst = 1'b1;
      seen_start = 1'b0;
      repeat (10) begin
         step();
         if (bus.tx_start) seen_start = 1'b1;
      end
      check("post_rst.no_start", 32'(seen_start), 0);
      check("post_rst.count", 32'(bus.count), 0);

      // Vector table: single byte, fill to full, overflow set/clear, push dropped on a pop edge.
      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            bus.wr_en        = vecs[i].we;
            bus.wr_data      = vecs[i].wd;
            bus.tx_done      = vecs[i].done;
            bus.clr_overflow = vecs[i].clr;
            step();
            check($sformatf("v%0d.tx_start", i), 32'(bus.tx_start), 32'(vecs[i].e_start));
            check($sformatf("v%0d.tx_data", i),  32'(bus.tx_data),  32'(vecs[i].e_data));
            check($sformatf("v%0d.count", i),    32'(bus.count),    32'(vecs[i].e_count));
            check($sformatf("v%0d.full", i),     32'(bus.full),     32'(vecs[i].e_full));
            check($sformatf("v%0d.empty", i),    32'(bus.empty),    32'(vecs[i].e_empty));
            check($sformatf("v%0d.overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d.busy", i),     32'(bus.busy),     32'(vecs[i].e_busy));
         end
         idle_inputs();
      end

      // Finish 0x02 then drain; 0x0A/0x0B/0x0C must never appear.
      repeat (2) step();
      done_pulse();
      for (int b = 3; b <= 9; b++) xmit(8'(b), 3);
      repeat (3) step();
      check("fill_drain.empty", 32'(bus.empty), 1);
      check("fill_drain.busy",  32'(bus.busy),  0);

      // Stream 20 bytes across pointer wrap with a concurrent pusher.
      fork
         begin
            for (int k = 0; k < 20; k++) begin
               guard = 0;
               while (bus.full && guard < 200) begin
                  step();
                  guard++;
               end
               push_byte(8'h10 + 8'(k));
            end
         end
         begin
            for (int k = 0; k < 20; k++) xmit(8'h10 + 8'(k), 5);
         end
      join
      repeat (3) step();
      check("wrap.empty",    32'(bus.empty),    1);
      check("wrap.count",    32'(bus.count),    0);
      check("wrap.overflow", 32'(bus.overflow), 0);

      // Simultaneous push and pop on the IDLE->START edge.
      push_byte(8'hA0);
      push_byte(8'hA1);
      push_byte(8'hA2);
      push_byte(8'hA3);
      check("simul.wait_count", 32'(bus.count), 3);
      check("simul.wait_data",  32'(bus.tx_data), 32'h A0);
      done_pulse();
      check("simul.idle_count", 32'(bus.count), 3);
      check("simul.idle_busy",  32'(bus.busy),  0);
      push_byte(8'h55);
      check("simul.count",    32'(bus.count),    3);
      check("simul.tx_start", 32'(bus.tx_start), 1);
      check("simul.tx_data",  32'(bus.tx_data),  32'h A1);
      repeat (2) step();
      done_pulse();
      xmit(8'hA2, 2);
      xmit(8'hA3, 2);
      xmit(8'h55, 2);
      repeat (2) step();
      check("simul.empty", 32'(bus.empty), 1);

      // Stray done in IDLE and in START.
      done_pulse();
      check("stray_idle.busy",  32'(bus.busy),     0);
      check("stray_idle.start", 32'(bus.tx_start), 0);
      push_byte(8'h77);
      bus.tx_done = 1'b1;
      step();
      check("stray_i2s.start", 32'(bus.tx_start), 1);
      check("stray_i2s.data",  32'(bus.tx_data),  32'h 77);
      step();
      bus.tx_done = 1'b0;
      check("stray_start.busy",  32'(bus.busy),     1);
      check("stray_start.start", 32'(bus.tx_start), 0);
      step();
      check("stray_wait.busy", 32'(bus.busy), 1);
      done_pulse();
      check("stray_end.busy",  32'(bus.busy),  0);
      check("stray_end.empty", 32'(bus.empty), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
